// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word fetch at a time, hands the result to
// decode, and follows downstream redirects, dropping responses already in flight.
module fetch_stage #(
   parameter logic [31:0] PCINIT = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        iresp_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [63:0] out_data,
   input  logic        out_ready
);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_OUT  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending;
   logic [63:0] r_outData;
   logic [31:0] w_redirTarget;

   assign w_redirTarget = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_REQ;
         r_pc      <= PCINIT;
         r_pending <= '0;
         r_outData <= '0;
      end else begin
         case (r_state)
            ST_REQ: begin
               if (iresp_ok) begin
                  if (redirect_valid) begin
                     r_pc <= w_redirTarget;
                  end else begin
                     r_outData <= {iresp_data, r_pc};
                     r_pc      <= r_pc + 32'd4;
                     r_state   <= ST_OUT;
                  end
               end else if (redirect_valid) begin
                  r_pending <= w_redirTarget;
                  r_state   <= ST_DROP;
               end
            end
            // The in-flight request must complete at its old address before
            // the newest redirect target can be issued.
            ST_DROP: begin
               if (iresp_ok) begin
                  r_pc    <= redirect_valid ? w_redirTarget : r_pending;
                  r_state <= ST_REQ;
               end else if (redirect_valid) begin
                  r_pending <= w_redirTarget;
               end
            end
            ST_OUT: begin
               if (redirect_valid) begin
                  r_pc    <= w_redirTarget;
                  r_state <= ST_REQ;
               end else if (out_ready) begin
                  r_state <= ST_REQ;
               end
            end
            default: r_state <= ST_REQ;
         endcase
      end
   end

   // Valids are masked during reset so an abandoned request is never visible.
   assign ireq_valid = !reset && ((r_state == ST_REQ) || (r_state == ST_DROP));
   assign out_valid  = !reset && (r_state == ST_OUT);
   assign ireq_addr  = r_pc;
   assign out_data   = r_outData;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a vector table, hand-written corner sequences, and a
// random phase checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

   localparam logic [31:0] PCINIT = 32'h8000_0000;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        iresp_ok;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready;

   int nCompared = 0;
   int nMismatched = 0;

   fetch_stage #(.PCINIT(PCINIT)) dut (
      .clk(clk),
      .reset(reset),
      .ireq_valid(ireq_valid),
      .ireq_addr(ireq_addr),
      .iresp_ok(iresp_ok),
      .iresp_data(iresp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        ok;
      logic [31:0] data;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        expIv;
      logic [31:0] expAddr;
      logic        expOv;
      logic [63:0] expOd;
   } vec_t;

   vec_t vecs[$];

   // Model: a fetch is either in flight (possibly already doomed by a redirect)
   // or an instruction is being offered to decode.
   bit          mFetching;
   bit          mDoomed;
   bit          mOffering;
   logic [31:0] mPc;
   logic [31:0] mTarget;
   logic [63:0] mOut;

   task automatic modelReset();
      mFetching = 1'b1;
      mDoomed   = 1'b0;
      mOffering = 1'b0;
      mPc       = PCINIT;
      mTarget   = '0;
      mOut      = '0;
   endtask

   task automatic modelStep();
      logic [31:0] aligned;
      aligned = redirect_pc & 32'hFFFF_FFFC;
      if (reset) begin
         modelReset();
      end else if (mOffering) begin
         if (redirect_valid) begin
            mPc = aligned;
            mOffering = 1'b0;
            mFetching = 1'b1;
         end else if (out_ready) begin
            mOffering = 1'b0;
            mFetching = 1'b1;
         end
      end else if (iresp_ok) begin
         if (mDoomed || redirect_valid) begin
            mPc = redirect_valid ? aligned : mTarget;
            mDoomed = 1'b0;
         end else begin
            mOut = {iresp_data, mPc};
            mPc = mPc + 32'd4;
            mFetching = 1'b0;
            mOffering = 1'b1;
         end
      end else if (redirect_valid) begin
         mDoomed = 1'b1;
         mTarget = aligned;
      end
   endtask

   task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ok, input logic [31:0] data,
                                input logic redir, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      reset          = rst;
      iresp_ok       = ok;
      iresp_data     = data;
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic expIv, input logic [31:0] expAddr,
                              input logic expOv, input logic [63:0] expOd);
      compare({tag, " ireq_valid"}, {63'd0, ireq_valid}, {63'd0, expIv});
      compare({tag, " ireq_addr"}, {32'd0, ireq_addr}, {32'd0, expAddr});
      compare({tag, " out_valid"}, {63'd0, out_valid}, {63'd0, expOv});
      compare({tag, " out_data"}, out_data, expOd);
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, !reset && mFetching, mPc, !reset && mOffering, mOut);
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelStep();
   endtask

   task automatic stepModel(input string tag, input logic rst, input logic ok, input logic [31:0] data,
                            input logic redir, input logic [31:0] rpc, input logic rdy);
      applyStimulus(rst, ok, data, redir, rpc, rdy);
      checkModel(tag);
   endtask

   task automatic addVec(input logic rst, input logic ok, input logic [31:0] data,
                         input logic redir, input logic [31:0] rpc, input logic rdy,
                         input logic expIv, input logic [31:0] expAddr,
                         input logic expOv, input logic [63:0] expOd);
      vec_t v;
      v.rst = rst; v.ok = ok; v.data = data; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.expIv = expIv; v.expAddr = expAddr; v.expOv = expOv; v.expOd = expOd;
      vecs.push_back(v);
   endtask

   initial begin
      logic [63:0] heldOut;

      reset = 1'b1; iresp_ok = 1'b0; iresp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      modelReset();

      // Reset state, zero-wait streaming, delayed response, redirects in flight and in OUT.
      addVec(1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_0000, 0, 64'h0);
      addVec(0, 1, 32'h0000_0013, 0, 32'h0,         1, 1, 32'h8000_0000, 0, 64'h0);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_0004, 1, 64'h0000_0013_8000_0000);
      addVec(0, 1, 32'h0000_0013, 0, 32'h0,         1, 1, 32'h8000_0004, 0, 64'h0000_0013_8000_0000);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_0008, 1, 64'h0000_0013_8000_0004);
      addVec(0, 1, 32'h0000_0013, 0, 32'h0,         1, 1, 32'h8000_0008, 0, 64'h0000_0013_8000_0004);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_000C, 1, 64'h0000_0013_8000_0008);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h8000_000C, 0, 64'h0000_0013_8000_0008);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h8000_000C, 0, 64'h0000_0013_8000_0008);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h8000_000C, 0, 64'h0000_0013_8000_0008);
      addVec(0, 1, 32'hDEAD_BEEF, 0, 32'h0,         1, 1, 32'h8000_000C, 0, 64'h0000_0013_8000_0008);
      addVec(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_0010, 1, 64'hDEAD_BEEF_8000_000C);
      addVec(0, 0, 32'h0,         1, 32'h8000_0100, 1, 1, 32'h8000_0010, 0, 64'hDEAD_BEEF_8000_000C);
      addVec(0, 0, 32'h0,         1, 32'h8000_0200, 1, 1, 32'h8000_0010, 0, 64'hDEAD_BEEF_8000_000C);
      addVec(0, 1, 32'h1111_1111, 0, 32'h0,         1, 1, 32'h8000_0010, 0, 64'hDEAD_BEEF_8000_000C);
      addVec(0, 1, 32'h2222_2222, 0, 32'h0,         0, 1, 32'h8000_0200, 0, 64'hDEAD_BEEF_8000_000C);
      addVec(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h8000_0204, 1, 64'h2222_2222_8000_0200);
      addVec(0, 0, 32'h0,         1, 32'h8000_0103, 0, 0, 32'h8000_0204, 1, 64'h2222_2222_8000_0200);
      addVec(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0100, 0, 64'h2222_2222_8000_0200);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].ok, vecs[i].data, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i), vecs[i].expIv, vecs[i].expAddr, vecs[i].expOv, vecs[i].expOd);
         finishCycle();
      end

      // Decode stalls for five cycles; stray responses in OUT must be ignored.
      stepModel("stall fetch", 0, 1, 32'hA5A5_A5A5, 0, 32'h0, 0);
      finishCycle();
      heldOut = {32'hA5A5_A5A5, 32'h8000_0100};
      for (int k = 0; k < 5; k++) begin
         stepModel($sformatf("stall%0d", k), 0, 1'(k % 2), 32'hFFFF_FFFF, 0, 32'h0, 0);
         compare($sformatf("stall%0d held", k), out_data, heldOut);
         compare($sformatf("stall%0d noreq", k), {63'd0, ireq_valid}, 64'd0);
         finishCycle();
      end
      stepModel("stall accept", 0, 0, 32'h0, 0, 32'h0, 1);
      compare("stall accept valid", {63'd0, out_valid}, 64'd1);
      finishCycle();
      stepModel("stall next", 0, 0, 32'h0, 0, 32'h0, 1);
      compare("stall next addr", {32'd0, ireq_addr}, {32'd0, 32'h8000_0104});
      finishCycle();

      // Reset while a doomed request is outstanding.
      stepModel("drop redir", 0, 0, 32'h0, 1, 32'h8000_0300, 1);
      finishCycle();
      stepModel("drop hold", 0, 0, 32'h0, 0, 32'h0, 1);
      finishCycle();
      stepModel("drop reset", 1, 1, 32'h5555_5555, 0, 32'h0, 1);
      compare("drop reset ireq_valid", {63'd0, ireq_valid}, 64'd0);
      finishCycle();
      for (int k = 0; k < 3; k++) begin
         stepModel($sformatf("post reset%0d", k), 0, 0, 32'h0, 0, 32'h0, 1);
         compare($sformatf("post reset%0d addr", k), {32'd0, ireq_addr}, {32'd0, PCINIT});
         compare($sformatf("post reset%0d nout", k), {63'd0, out_valid}, 64'd0);
         finishCycle();
      end
      stepModel("post reset fetch", 0, 1, 32'h0000_0077, 0, 32'h0, 1);
      finishCycle();
      stepModel("post reset out", 0, 0, 32'h0, 0, 32'h0, 1);
      compare("post reset out_data", out_data, {32'h0000_0077, PCINIT});
      finishCycle();

      // Random traffic, including pc wrap via redirects near the top of memory.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         stepModel($sformatf("rand%0d", n), ($urandom_range(0, 99) == 0),
                   ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 7) == 0),
                   rpc, 1'($urandom_range(0, 1)));
         finishCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PCINIT, default 32'h8000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  SHALL assert while an instruction fetch request is outstanding.
REQ-005 ireq_addr  output  32  SHALL carry the fetch address (word-aligned).
REQ-006 iresp_ok  input  1  SHALL mark the cycle in which iresp_data is valid for the outstanding request.
REQ-007 iresp_data  input  32  instruction word.
REQ-008 redirect_valid  input  1  single-cycle pulse requesting a PC change (branch/jump resolved downstream).
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 out_valid  output  1  SHALL assert when out_data holds a fetched instruction for decode.
REQ-011 out_data  output  64  fetch_data_t {instruction[63:32], pc[31:0]}.
REQ-012 out_ready  input  1  decode accepts out_data when out_valid and out_ready are both 1.

Function
REQ-013 The block SHALL be a three-state FSM: REQ, OUT, DROP; out_valid SHALL be 1 only in OUT; ireq_valid SHALL be 1 only in REQ or DROP.
REQ-014 ireq_addr SHALL equal the internal pc register; ireq_valid and ireq_addr SHALL stay stable from assertion through the iresp_ok cycle inclusive.
REQ-015 iresp_ok SHALL be sampled only in REQ/DROP; iresp_ok in OUT SHALL be ignored; iresp_ok in the same cycle as ireq_valid first asserts SHALL be legal (zero-wait memory).
REQ-016 REQ, iresp_ok=1, no redirect: out_data <= {iresp_data, pc}, pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), next state OUT.
REQ-017 REQ, redirect_valid=1 and iresp_ok=1: response discarded, pc <= redirect_pc, stay REQ.
REQ-018 REQ, redirect_valid=1 and iresp_ok=0: target latched into pending register, next state DROP; pc/ireq_addr unchanged.
REQ-019 DROP: request held at old address; a further redirect SHALL overwrite the pending target (newest wins); on iresp_ok the response is discarded, pc <= pending target (or redirect_pc if a redirect arrives in that same cycle), next state REQ.
REQ-020 OUT: out_data and out_valid SHALL be held stable while out_ready=0; on out_ready=1 next state REQ.
REQ-021 OUT, redirect_valid=1: pc <= redirect_pc, next state REQ; if out_ready=1 in that cycle the transfer SHALL still count as accepted (squashing it is decode's responsibility).
REQ-022 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-023 All outputs SHALL be driven from registered state only (no combinational path from out_ready, iresp_ok or redirect_valid to any output).
REQ-024 Throughput: one instruction per two cycles with zero-wait memory and out_ready=1; latency from ireq_valid rise to out_valid rise = memory wait + 1 cycle.

Reset
REQ-025 While reset=1: state <= REQ, pc <= PCINIT, pending target <= 0, out_data <= 0; ireq_valid and out_valid SHALL be forced to 0 in the reset cycle.
REQ-026 Reset mid-request SHALL abandon the outstanding request without waiting for iresp_ok; iresp_ok during reset SHALL be ignored.
REQ-027 First cycle after reset deassertion: ireq_valid=1, ireq_addr=PCINIT.

Verification
REQ-028 Zero-wait memory returning 32'h0000_0013 each fetch, out_ready=1 -> out_data pcs 8000_0000, 8000_0004, 8000_0008 on alternating cycles, out_valid pattern 0,1,0,1.
REQ-029 iresp_ok delayed 3 cycles -> ireq_addr stable 4 cycles, out_valid rises the cycle after iresp_ok.
REQ-030 out_ready=0 for 5 cycles in OUT -> out_data unchanged, ireq_valid=0 throughout; accept on cycle 6, next request at pc+4.
REQ-031 redirect to 8000_0100 while request to 8000_0010 pending, then redirect to 8000_0200 before iresp_ok -> old response dropped (no out_valid), next ireq_addr=8000_0200.
REQ-032 redirect to 8000_0103 in OUT with out_ready=0 -> next cycle out_valid=0, ireq_addr=8000_0100.
REQ-033 reset asserted during DROP -> next cycle after deassertion ireq_addr=PCINIT, pending target discarded, no out_valid until a fresh iresp_ok.
